encrypt_seq: RTL and testbench

- Sequential encryptor that sits directly upstream of the decrypt stage and produces the cipher bytes that stage consumes.
- Builds a keyed 5x5 Polybius square from the secret, one candidate per clock.
- Then emits one cipher byte per clock: byte = code(text char) + code(secret char).
- Start/busy/done handshake.

---
 rtl/encrypt_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_encrypt_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/encrypt_seq.sv
// encrypt_seq -- sequential Polybius-square encryptor.
//
// A run builds a keyed 5x5 square from the secret (one candidate letter per
// clock: the secret characters first, then 'A'..'Z'), then emits one cipher
// byte per clock.
// Cipher byte k = code(text[k]) + code(secret[k mod S]). A code is
// (row+1)*10 + (col+1).
// 'J' shares the 'I' cell. A byte whose text or secret character is not a
// letter is written as 0 and raises o_r_error.
//
// Optional build macro: LOWERCASE_FOLD_EN -- when defined, 'a'..'z' fold to
// upper case before mapping. When undefined, lower-case bytes are invalid.
//
// Ports:
//   i_w_clk     clock, rising edge
//   i_w_rst     synchronous active-high reset
//   i_w_start   start request, honoured only in IDLE
//   i_w_text    plaintext, char 0 in MSB byte
//   i_w_secret  secret, char 0 in MSB byte
//   o_r_cipher  cipher bytes, byte k pairs with text char k (MSB first)
//   o_r_busy    high while building the square or encrypting
//   o_r_done    one-cycle pulse when o_r_cipher is complete
//   o_r_error   an invalid character was seen in the current run
module encrypt_seq #(
  parameter int p_text_length   = 6,
  parameter int p_secret_length = 6
) (
  input  logic                         i_w_clk,
  input  logic                         i_w_rst,
  input  logic                         i_w_start,
  input  logic [p_text_length*8-1:0]   i_w_text,
  input  logic [p_secret_length*8-1:0] i_w_secret,
  output logic [p_text_length*8-1:0]   o_r_cipher,
  output logic                         o_r_busy,
  output logic                         o_r_done,
  output logic                         o_r_error
);

  localparam int TW      = p_text_length * 8;
  localparam int SW      = p_secret_length * 8;
  localparam int BUILD_N = p_secret_length + 26;
  localparam int CNT_MAX = (BUILD_N > p_text_length) ? BUILD_N : p_text_length;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TIDX_W  = (p_text_length > 1) ? $clog2(p_text_length) : 1;
  localparam int SIDX_W  = (p_secret_length > 1) ? $clog2(p_secret_length) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_ENC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     text_q, text_d;
  logic [SW-1:0]     secret_q, secret_d;
  logic [TW-1:0]     cipher_q, cipher_d;
  logic              error_q, error_d;
  logic [25:0]       mask_q, mask_d;
  logic [5:0]        code_q [26];
  logic [5:0]        code_d [26];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        pos_q, pos_d;
  logic [2:0]        row_q, row_d;
  logic [2:0]        col_q, col_d;
  logic [SIDX_W-1:0] sidx_q, sidx_d;

  logic [7:0] txt_ch [p_text_length];
  logic [7:0] sec_ch [p_secret_length];
  logic [7:0] cand;
  logic [5:0] cand_m, txt_m, sec_m;
  logic [7:0] enc_byte;

  // Returns {valid, letter index}; 'J' shares index 8 with 'I'.
  function automatic logic [5:0] map_char(input logic [7:0] c);
    logic [7:0] u;
    logic [7:0] off;
    logic [4:0] idx;
    u = c;
`ifdef LOWERCASE_FOLD_EN
    if (c >= 8'h61 && c <= 8'h7A) u = c - 8'h20;
`endif
    map_char = 6'd0;
    off      = u - 8'h41;
    idx      = off[4:0];
    if (u >= 8'h41 && u <= 8'h5A) begin
      if (idx == 5'd9) idx = 5'd8;
      map_char = {1'b1, idx};
    end
  endfunction

  function automatic logic [5:0] square_code(input logic [2:0] row,
                                             input logic [2:0] col);
    logic [5:0] r;
    r = {3'b000, row} + 6'd1;
    square_code = r * 6'd10 + {3'b000, col} + 6'd1;
  endfunction

  // Codes are at most 55, so the sum never exceeds 110.
  function automatic logic [7:0] code_sum(input logic [5:0] a, input logic [5:0] b);
    code_sum = {2'b00, a} + {2'b00, b};
  endfunction

  always_comb begin
    for (int i = 0; i < p_text_length; i++)
      txt_ch[i] = text_q[(p_text_length-1-i)*8 +: 8];
    for (int i = 0; i < p_secret_length; i++)
      sec_ch[i] = secret_q[(p_secret_length-1-i)*8 +: 8];
  end

  always_comb begin
    state_d  = state_q;
    text_d   = text_q;
    secret_d = secret_q;
    cipher_d = cipher_q;
    error_d  = error_q;
    mask_d   = mask_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    row_d    = row_q;
    col_d    = col_q;
    sidx_d   = sidx_q;
    cand     = 8'h00;
    cand_m   = 6'd0;
    txt_m    = 6'd0;
    sec_m    = 6'd0;
    enc_byte = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (i_w_start) begin
          text_d   = i_w_text;
          secret_d = i_w_secret;
          cipher_d = '0;
          error_d  = 1'b0;
          mask_d   = '0;
          for (int i = 0; i < 26; i++) code_d[i] = 6'd0;
          cnt_d    = '0;
          pos_d    = 5'd0;
          row_d    = 3'd0;
          col_d    = 3'd0;
          sidx_d   = '0;
          state_d  = S_BUILD;
        end
      end

      S_BUILD: begin
        if (cnt_q < CNT_W'(p_secret_length))
          cand = sec_ch[sidx_q];
        else
          cand = 8'h41 + 8'(cnt_q - CNT_W'(p_secret_length));
        cand_m = map_char(cand);
        // Only secret candidates can be invalid; the alphabet pass never is.
        if (!cand_m[5]) begin
          error_d = 1'b1;
        end else if (!mask_q[cand_m[4:0]] && pos_q != 5'd25) begin
          code_d[cand_m[4:0]] = square_code(row_q, col_q);
          mask_d[cand_m[4:0]] = 1'b1;
          pos_d = pos_q + 5'd1;
          if (col_q == 3'd4) begin
            col_d = 3'd0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
        if (cnt_q < CNT_W'(p_secret_length))
          sidx_d = (sidx_q == SIDX_W'(p_secret_length-1)) ? '0 : sidx_q + 1'b1;
        // Cycle count is fixed even once the square is full.
        if (cnt_q == CNT_W'(BUILD_N-1)) begin
          cnt_d   = '0;
          sidx_d  = '0;
          state_d = S_ENC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_ENC: begin
        txt_m = map_char(txt_ch[cnt_q[TIDX_W-1:0]]);
        sec_m = map_char(sec_ch[sidx_q]);
        if (txt_m[5] && sec_m[5])
          enc_byte = code_sum(code_q[txt_m[4:0]], code_q[sec_m[4:0]]);
        else
          error_d = 1'b1;
        for (int i = 0; i < p_text_length; i++)
          if (TIDX_W'(i) == cnt_q[TIDX_W-1:0])
            cipher_d[(p_text_length-1-i)*8 +: 8] = enc_byte;
        sidx_d = (sidx_q == SIDX_W'(p_secret_length-1)) ? '0 : sidx_q + 1'b1;
        if (cnt_q == CNT_W'(p_text_length-1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_rst) begin
      state_q  <= S_IDLE;
      text_q   <= '0;
      secret_q <= '0;
      cipher_q <= '0;
      error_q  <= 1'b0;
      mask_q   <= '0;
      for (int i = 0; i < 26; i++) code_q[i] <= 6'd0;
      cnt_q    <= '0;
      pos_q    <= 5'd0;
      row_q    <= 3'd0;
      col_q    <= 3'd0;
      sidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      text_q   <= text_d;
      secret_q <= secret_d;
      cipher_q <= cipher_d;
      error_q  <= error_d;
      mask_q   <= mask_d;
      for (int i = 0; i < 26; i++) code_q[i] <= code_d[i];
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      row_q    <= row_d;
      col_q    <= col_d;
      sidx_q   <= sidx_d;
    end
  end

  assign o_r_cipher = cipher_q;
  assign o_r_error  = error_q;
  assign o_r_busy   = (state_q == S_BUILD) || (state_q == S_ENC);
  assign o_r_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_encrypt_seq.sv
// Directed bench for encrypt_seq with hand-computed cipher values.
module tb_encrypt_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [47:0] text;
  logic [47:0] secret;
  logic [47:0] cipher;
  logic        busy;
  logic        done;
  logic        error;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [47:0] BASIC_EXP = 48'h16181A1C1E18;
  localparam logic [47:0] FOLD_EXP  = 48'h232300420017;

  always #5 clk = ~clk;

  encrypt_seq #(.p_text_length(6), .p_secret_length(6)) dut (
    .i_w_clk   (clk),
    .i_w_rst   (rst),
    .i_w_start (start),
    .i_w_text  (text),
    .i_w_secret(secret),
    .o_r_cipher(cipher),
    .o_r_busy  (busy),
    .o_r_done  (done),
    .o_r_error (error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge and wait for done; lat counts edges from the
  // start edge to the done cycle, bz counts busy cycles before done.
  task automatic run(input logic [47:0] t, input logic [47:0] s,
                     output int lat, output int bz);
    text   = t;
    secret = s;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat    = 1;
    bz     = 0;
    while (!done && lat < 200) begin
      bz += int'(busy);
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bz, idx, first, ndone;
    rst    = 1'b1;
    start  = 1'b0;
    text   = '0;
    secret = '0;
    tick();
    tick();
    check("rst_cipher", 64'(cipher), 64'h0);
    check("rst_busy",   64'(busy),   64'h0);
    check("rst_done",   64'(done),   64'h0);
    check("rst_error",  64'(error),  64'h0);
    rst = 1'b0;
    tick();

    // Basic run
    run("DANILA", "DANILA", lat, bz);
    check("basic_latency", 64'(lat),    64'd39);
    check("basic_busy",    64'(bz),     64'd38);
    check("basic_cipher",  64'(cipher), 64'(BASIC_EXP));
    check("basic_error",   64'(error),  64'h0);
    tick();
    tick();
    tick();
    check("basic_hold",    64'(cipher), 64'(BASIC_EXP));
    check("basic_done_lo", 64'(done),   64'h0);

    // J folding and invalid characters
    run("JI Z A", "BBBBBB", lat, bz);
    check("fold_cipher", 64'(cipher), 64'(FOLD_EXP));
    check("fold_error",  64'(error),  64'h1);
    tick();

    // Start pulse during ENC is ignored
    text   = "DANILA";
    secret = "DANILA";
    start  = 1'b1;
    tick();
    start  = 1'b0;
    idx    = 1;
    while (idx < 34) begin
      tick();
      idx++;
    end
    start = 1'b1;
    tick();
    idx++;
    start = 1'b0;
    while (!done && idx < 200) begin
      tick();
      idx++;
    end
    check("encpulse_latency", 64'(idx),    64'd39);
    check("encpulse_cipher",  64'(cipher), 64'(BASIC_EXP));
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      ndone += int'(done);
    end
    check("encpulse_extra_done", 64'(ndone), 64'd0);

    // Start held high: back-to-back runs
    start = 1'b1;
    tick();
    idx = 1;
    while (!done && idx < 200) begin
      tick();
      idx++;
    end
    first = idx;
    check("hold_first_lat",    64'(first),  64'd39);
    check("hold_first_cipher", 64'(cipher), 64'(BASIC_EXP));
    tick();
    idx++;
    while (!done && idx < 200) begin
      tick();
      idx++;
    end
    check("hold_gap",           64'(idx - first), 64'd40);
    check("hold_second_cipher", 64'(cipher),      64'(BASIC_EXP));
    start = 1'b0;
    tick();
    tick();
    tick();

    // Reset in the third ENC cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    idx   = 1;
    while (idx < 35) begin
      tick();
      idx++;
    end
    rst = 1'b1;
    tick();
    check("midrst_cipher", 64'(cipher), 64'h0);
    check("midrst_busy",   64'(busy),   64'h0);
    check("midrst_done",   64'(done),   64'h0);
    check("midrst_error",  64'(error),  64'h0);
    rst = 1'b0;
    tick();
    run("DANILA", "DANILA", lat, bz);
    check("rerun_latency", 64'(lat),    64'd39);
    check("rerun_cipher",  64'(cipher), 64'(BASIC_EXP));
    check("rerun_error",   64'(error),  64'h0);
    tick();

    // Lower-case plaintext
    run("danila", "DANILA", lat, bz);
`ifdef LOWERCASE_FOLD_EN
    check("lower_cipher", 64'(cipher), 64'(BASIC_EXP));
    check("lower_error",  64'(error),  64'h0);
`else
    check("lower_cipher", 64'(cipher), 64'h0);
    check("lower_error",  64'(error),  64'h1);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
